// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory and its commit-side store buffer:
// funct3 encodings, the buffer entry layout and the byte-mask / load-extend helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } sb_entry_t;

    // Byte lanes touched by an access of the given width (signedness ignored).
    function automatic logic [3:0] funct3_to_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 4'b0001;
            F3_H, F3_HU: return 4'b0011;
            F3_W:        return 4'b1111;
            default:     return 4'b0000;
        endcase
    endfunction

    // Sign/zero extension of a little-endian raw word; unknown encodings read as 0.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            F3_B:    return {{24{raw[7]}}, raw[7:0]};
            F3_H:    return {{16{raw[15]}}, raw[15:0]};
            F3_W:    return raw;
            F3_BU:   return {24'h0, raw[7:0]};
            F3_HU:   return {16'h0, raw[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_sb_fifo.sv
// Circular store buffer. Drains its head entry every cycle it is non-empty and
// offers two combinational forwarding ports (load and check) that return, per
// byte of the queried word, the data of the youngest entry covering that byte.
module data_sb_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int MEM_AW = 12,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  sb_entry_t         push_entry,
    output sb_entry_t         head_entry,
    output logic              drain,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    input  logic [MEM_AW-1:0] ld_query_addr,
    output logic [3:0]        ld_fwd_hit,
    output logic [31:0]       ld_fwd_data,
    input  logic [MEM_AW-1:0] chk_query_addr,
    output logic [3:0]        chk_fwd_hit,
    output logic [31:0]       chk_fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t          entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               accept;
    logic [MEM_AW-1:0]  q_addr [2];

    assign full       = count == CNT_W'(DEPTH);
    assign empty      = count == '0;
    assign drain      = !empty;
    assign accept     = push && !full;
    assign head_entry = entries[head];
    assign q_addr[0]  = ld_query_addr;
    assign q_addr[1]  = chk_query_addr;

    // Pointer and occupancy bookkeeping; reset throws away anything still buffered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (drain)  head <= head + 1'b1;
            count <= count + CNT_W'(accept) - CNT_W'(drain);
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (accept) entries[tail] <= push_entry;
    end

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [3:0]  hit;
        logic [31:0] data;

        // Walk oldest to youngest so a younger covering entry overwrites an older one.
        always_comb begin
            hit  = '0;
            data = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (CNT_W'(k) < count) begin
                    for (int j = 0; j < 4; j++) begin
                        for (int i = 0; i < 4; i++) begin
                            if (entries[head + PTR_W'(k)].mask[j] &&
                                (entries[head + PTR_W'(k)].addr[MEM_AW-1:0] + MEM_AW'(j)) ==
                                (q_addr[p] + MEM_AW'(i))) begin
                                hit[i]        = 1'b1;
                                data[8*i +: 8] = entries[head + PTR_W'(k)].data[8*j +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign ld_fwd_hit   = g_fwd[0].hit;
    assign ld_fwd_data  = g_fwd[0].data;
    assign chk_fwd_hit  = g_fwd[1].hit;
    assign chk_fwd_data = g_fwd[1].data;

endmodule

// File: rtl/data_memory_sb.sv
// Byte-addressable data memory fronted by a commit-side store buffer.
// Loads and ROB checks see memory merged with buffered stores, one cycle later.
// Define DMEM_MISALIGN_TRAP_EN to drop misaligned stores and trap misaligned loads;
// otherwise misaligned accesses are done bytewise with address wrap.
module data_memory_sb
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32,
    parameter int SB_DEPTH  = 4,
    parameter int CNT_W     = $clog2(SB_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [2:0]        st_funct3,
    input  logic [31:0]       st_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    output logic              ld_data_valid,
    output logic [31:0]       ld_data,
    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [2:0]        chk_funct3,
    input  logic [31:0]       chk_value,
    output logic              chk_mismatch,
    output logic              misalign_exc,
    output logic [CNT_W-1:0]  sb_count,
    output logic              sb_empty
);

    localparam int MEM_AW = $clog2(MEM_BYTES);

    logic [7:0]  mem [MEM_BYTES];
    sb_entry_t   head_entry;
    sb_entry_t   new_entry;
    logic        drain;
    logic        full;
    logic        st_f3_ok;
    logic        st_drop;
    logic        st_push;
    logic [3:0]  ld_hit;
    logic [31:0] ld_fwd;
    logic [3:0]  chk_hit;
    logic [31:0] chk_fwd;
    logic [31:0] ld_raw;
    logic [31:0] chk_raw;
    logic [31:0] ld_result;
    logic        unused_addr_bits;

    assign st_ready  = !full;
    assign st_f3_ok  = (st_funct3 == F3_B) || (st_funct3 == F3_H) || (st_funct3 == F3_W);
    assign new_entry = '{addr: 32'(st_addr), mask: funct3_to_mask(st_funct3), data: st_data};
    assign st_push   = st_valid && st_ready && !st_drop;

    assign unused_addr_bits = ^{ld_addr[ADDR_W-1:MEM_AW], chk_addr[ADDR_W-1:MEM_AW],
                                head_entry.addr[31:MEM_AW]};

    data_sb_fifo #(
        .DEPTH  (SB_DEPTH),
        .MEM_AW (MEM_AW)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (st_push),
        .push_entry     (new_entry),
        .head_entry     (head_entry),
        .drain          (drain),
        .full           (full),
        .empty          (sb_empty),
        .count          (sb_count),
        .ld_query_addr  (ld_addr[MEM_AW-1:0]),
        .ld_fwd_hit     (ld_hit),
        .ld_fwd_data    (ld_fwd),
        .chk_query_addr (chk_addr[MEM_AW-1:0]),
        .chk_fwd_hit    (chk_hit),
        .chk_fwd_data   (chk_fwd)
    );

    // Retire the head entry into the array; byte addresses wrap past the top.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int j = 0; j < 4; j++) begin
                if (head_entry.mask[j])
                    mem[head_entry.addr[MEM_AW-1:0] + MEM_AW'(j)] <= head_entry.data[8*j +: 8];
            end
        end
    end

    // Merged view: a forwarded byte wins over the (not yet updated) array byte.
    always_comb begin
        ld_raw  = '0;
        chk_raw = '0;
        for (int i = 0; i < 4; i++) begin
            ld_raw[8*i +: 8]  = ld_hit[i]  ? ld_fwd[8*i +: 8]
                                           : mem[ld_addr[MEM_AW-1:0] + MEM_AW'(i)];
            chk_raw[8*i +: 8] = chk_hit[i] ? chk_fwd[8*i +: 8]
                                           : mem[chk_addr[MEM_AW-1:0] + MEM_AW'(i)];
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic ld_misalign;

    assign st_drop     = !st_f3_ok || is_misaligned(st_funct3, st_addr[1:0]);
    assign ld_misalign = ld_valid && is_misaligned(ld_funct3, ld_addr[1:0]);
    assign ld_result   = ld_misalign ? 32'h0 : load_extend(ld_funct3, ld_raw);

    // Trap flag lines up with the load result it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_exc <= 1'b0;
        else       misalign_exc <= ld_misalign;
    end
`else
    assign st_drop      = !st_f3_ok;
    assign ld_result    = load_extend(ld_funct3, ld_raw);
    assign misalign_exc = 1'b0;
`endif

    // Register load results and the ROB verification outcome.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_data_valid <= 1'b0;
            ld_data       <= '0;
            chk_mismatch  <= 1'b0;
        end else begin
            ld_data_valid <= ld_valid;
            if (ld_valid) ld_data <= ld_result;
            chk_mismatch  <= chk_valid && (load_extend(chk_funct3, chk_raw) != chk_value);
        end
    end

endmodule

// File: tb/tb_data_memory_sb.sv
// Scoreboard bench for data_memory_sb: the stimulus process models memory as an
// architectural byte image (all committed stores) plus a drained image, and pushes
// expected load/check results; a monitor process pops and compares them.
`timescale 1ns/1ps
module tb_data_memory_sb;

    localparam int MEM_BYTES = 4096;
    localparam int ADDR_W    = 32;
    localparam int SB_DEPTH  = 4;
    localparam int CNT_W     = $clog2(SB_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [2:0]        st_funct3;
    logic [31:0]       st_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_funct3;
    logic              ld_data_valid;
    logic [31:0]       ld_data;
    logic              chk_valid;
    logic [ADDR_W-1:0] chk_addr;
    logic [2:0]        chk_funct3;
    logic [31:0]       chk_value;
    logic              chk_mismatch;
    logic              misalign_exc;
    logic [CNT_W-1:0]  sb_count;
    logic              sb_empty;

    always #5 clk = ~clk;

    data_memory_sb #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W),
        .SB_DEPTH  (SB_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_funct3     (st_funct3),
        .st_data       (st_data),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_funct3     (ld_funct3),
        .ld_data_valid (ld_data_valid),
        .ld_data       (ld_data),
        .chk_valid     (chk_valid),
        .chk_addr      (chk_addr),
        .chk_funct3    (chk_funct3),
        .chk_value     (chk_value),
        .chk_mismatch  (chk_mismatch),
        .misalign_exc  (misalign_exc),
        .sb_count      (sb_count),
        .sb_empty      (sb_empty)
    );

    typedef struct {
        int unsigned addr;
        int          nbytes;
        logic [31:0] data;
    } st_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  arch_img [MEM_BYTES];
    logic [7:0]  mem_img  [MEM_BYTES];
    st_t         pending [$];
    logic [31:0] ld_exp_q [$];
    bit          mis_exp_q [$];
    bit          ldv_q [$];
    bit          chk_q [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input int unsigned a, input logic [2:0] f3);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = arch_img[(a + i) % MEM_BYTES];
        case (f3)
            3'b000:  return {{24{b[0][7]}}, b[0]};
            3'b001:  return {{16{b[1][7]}}, b[1], b[0]};
            3'b010:  return {b[3], b[2], b[1], b[0]};
            3'b100:  return {24'h0, b[0]};
            3'b101:  return {16'h0, b[1], b[0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_misaligned(input int unsigned a, input logic [2:0] f3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'b010 && (a % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One clock of stimulus: check status, drive, predict, then advance the model.
    task automatic applyStimulus(input bit sv, input int unsigned sa, input logic [2:0] sf,
                                 input logic [31:0] sd,
                                 input bit lv, input int unsigned la, input logic [2:0] lf,
                                 input bit cv, input int unsigned ca, input logic [2:0] cf,
                                 input logic [31:0] cval);
        bit accept;
        bit mis;
        int nb;
        @(negedge clk);
        checkOutput("sb_count", 32'(sb_count), 32'(pending.size()));
        checkOutput("st_ready", 32'(st_ready), 32'(pending.size() < SB_DEPTH));
        checkOutput("sb_empty", 32'(sb_empty), 32'(pending.size() == 0));
        st_valid = sv; st_addr = sa; st_funct3 = sf; st_data = sd;
        ld_valid = lv; ld_addr = la; ld_funct3 = lf;
        chk_valid = cv; chk_addr = ca; chk_funct3 = cf; chk_value = cval;
        nb = (sf == 3'b000) ? 1 : (sf == 3'b001) ? 2 : 4;
        accept = sv && (pending.size() < SB_DEPTH) && (sf <= 3'b010) && !model_misaligned(sa, sf);
        ldv_q.push_back(lv);
        if (lv) begin
            mis = model_misaligned(la, lf);
            ld_exp_q.push_back(mis ? 32'h0 : model_load(la, lf));
            mis_exp_q.push_back(mis);
        end
        chk_q.push_back(cv && (model_load(ca, cf) !== cval));
        @(posedge clk);
        if (pending.size() > 0) begin
            st_t e = pending.pop_front();
            for (int i = 0; i < e.nbytes; i++)
                mem_img[(e.addr + i) % MEM_BYTES] = e.data[8*i +: 8];
        end
        if (accept) begin
            st_t n;
            n.addr = sa; n.nbytes = nb; n.data = sd;
            pending.push_back(n);
            for (int i = 0; i < nb; i++) arch_img[(sa + i) % MEM_BYTES] = sd[8*i +: 8];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ld_valid"}, 32'(ld_data_valid), 32'h0);
        checkOutput({tag, "_ld_data"}, ld_data, 32'h0);
        checkOutput({tag, "_chk_mismatch"}, 32'(chk_mismatch), 32'h0);
        checkOutput({tag, "_misalign"}, 32'(misalign_exc), 32'h0);
        checkOutput({tag, "_sb_count"}, 32'(sb_count), 32'h0);
        checkOutput({tag, "_sb_empty"}, 32'(sb_empty), 32'h1);
    endtask

    // Asynchronous reset between edges; buffered stores are lost from the model too.
    task automatic midReset();
        #2;
        reset = 1'b1;
        #1;
        checkResetState("mid_reset");
        st_valid = 0; ld_valid = 0; chk_valid = 0;
        pending.delete(); ldv_q.delete(); ld_exp_q.delete(); mis_exp_q.delete(); chk_q.delete();
        arch_img = mem_img;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int unsigned pick_addr();
        if ($urandom_range(0, 3) == 0) return MEM_BYTES - 8 + $urandom_range(0, 7);
        return $urandom_range(0, 63);
    endfunction

    task automatic randomCycles(input int n);
        for (int c = 0; c < n; c++) begin
            int unsigned ca = pick_addr();
            logic [2:0]  cf = 3'($urandom_range(0, 7));
            logic [31:0] cval = ($urandom_range(0, 1) == 0) ? model_load(ca, cf) : $urandom;
            applyStimulus($urandom_range(0, 1) == 1, pick_addr(), 3'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 1) == 1, pick_addr(), 3'($urandom_range(0, 7)),
                          $urandom_range(0, 2) == 0, ca, cf, cval);
        end
    endtask

    // Monitor: compares each registered response against the scoreboard queues.
    always @(posedge clk) begin
        #1;
        if (ldv_q.size() > 0) checkOutput("ld_data_valid", 32'(ld_data_valid), 32'(ldv_q.pop_front()));
        if (ld_data_valid) begin
            if (ld_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_load actual=valid expected=none at %0t", $time);
            end else begin
                checkOutput("ld_data", ld_data, ld_exp_q.pop_front());
                checkOutput("misalign_exc", 32'(misalign_exc), 32'(mis_exp_q.pop_front()));
            end
        end else if (!reset) begin
            checkOutput("misalign_idle", 32'(misalign_exc), 32'h0);
        end
        if (chk_q.size() > 0) checkOutput("chk_mismatch", 32'(chk_mismatch), 32'(chk_q.pop_front()));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        st_valid = 0; st_addr = 0; st_funct3 = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; ld_funct3 = 0;
        chk_valid = 0; chk_addr = 0; chk_funct3 = 0; chk_value = 0;
        #1;
        checkResetState("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Known contents for the address window the bench uses.
        for (int a = 0; a < 72; a += 4) applyStimulus(1, a, 3'b010, $urandom, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, MEM_BYTES - 8, 3'b010, $urandom, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, MEM_BYTES - 4, 3'b010, $urandom, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        $display("[TB] forwarding then memory read");
        applyStimulus(1, 32'h10, 3'b010, 32'h11223344, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h10, 3'b010, 0, 0, 0, 0);
        idle(3);
        applyStimulus(0, 0, 0, 0, 1, 32'h10, 3'b010, 0, 0, 0, 0);

        $display("[TB] youngest byte wins and extension");
        applyStimulus(1, 32'h20, 3'b000, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h20, 3'b000, 32'h7F, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 3'b000, 0, 0, 0, 0);
        applyStimulus(1, 32'h20, 3'b000, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 3'b100, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h20, 3'b000, 0, 0, 0, 0);

        $display("[TB] back-to-back store burst");
        for (int i = 0; i <= SB_DEPTH; i++)
            applyStimulus(1, 32'h40 + i, 3'b000, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i <= SB_DEPTH; i++)
            applyStimulus(0, 0, 0, 0, 1, 32'h40 + i, 3'b100, 0, 0, 0, 0);

        $display("[TB] store wrapping past the top");
        applyStimulus(1, MEM_BYTES - 2, 3'b010, 32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, MEM_BYTES - 2, 3'b010, 0, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 0, 1, 0, 3'b001, 0, 0, 0, 0);

        $display("[TB] ROB check port");
        applyStimulus(1, 32'h30, 3'b010, 32'h5, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h30, 3'b010, 32'h5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h30, 3'b010, 32'h6);

        $display("[TB] randomized traffic");
        randomCycles(400);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(1, 32'h8, 3'b010, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'hC, 3'b010, 32'hCAFEF00D, 1, 32'h8, 3'b010, 1, 32'h30, 3'b010, 32'h6);
        midReset();
        applyStimulus(0, 0, 0, 0, 1, 32'hC, 3'b010, 0, 0, 0, 0);
        randomCycles(200);
        idle(4);

        checkOutput("ld_queue_drained", 32'(ld_exp_q.size()), 32'h0);
        checkOutput("sb_drained", 32'(sb_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
